// File: rtl/clk_period_meter.sv
// Measures period and high phase of a synchronous divided clock in clk_in cycles.
// Optional feature: define PERIOD_CHECK_EN to compare each period against exp_period.
module clk_period_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_count,
  output logic             timeout,
  output logic             period_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             sig_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [CNT_W-1:0] period_next_s;
  logic [CNT_W-1:0] high_time_next_s;
  logic [CNT_W-1:0] edge_count_next_s;
  logic             meas_valid_next_s;
  logic             timeout_next_s;
  logic             period_err_next_s;
  logic             rise_s;
  logic             fall_s;
  logic             sat_s;

  assign rise_s    = sig_in & ~sig_q_r;
  assign fall_s    = ~sig_in & sig_q_r;
  assign sat_s     = (cnt_r == CNT_MAX);
  assign cnt_inc_s = sat_s ? CNT_MAX : (cnt_r + CNT_ONE);

  // State, counter, edge detector and all outputs register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      sig_q_r    <= 1'b0;
      cnt_r      <= CNT_ZERO;
      period     <= CNT_ZERO;
      high_time  <= CNT_ZERO;
      edge_count <= CNT_ZERO;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      period_err <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      sig_q_r    <= sig_in;
      cnt_r      <= cnt_next_s;
      period     <= period_next_s;
      high_time  <= high_time_next_s;
      edge_count <= edge_count_next_s;
      meas_valid <= meas_valid_next_s;
      timeout    <= timeout_next_s;
      period_err <= period_err_next_s;
    end
  end

  // Next-state and next-output logic; edges win over saturation.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    period_next_s     = period;
    high_time_next_s  = high_time;
    edge_count_next_s = edge_count;
    meas_valid_next_s = 1'b0;
    timeout_next_s    = 1'b0;
    period_err_next_s = period_err;

    case (state_r)
      IDLE: begin
        if (rise_s) begin
          cnt_next_s   = CNT_ONE;
          state_next_s = HIGH;
        end else begin
          cnt_next_s   = CNT_ZERO;
        end
      end

      HIGH: begin
        if (fall_s) begin
          high_time_next_s = cnt_r;
          cnt_next_s       = cnt_inc_s;
          state_next_s     = LOW;
        end else if (sat_s) begin
          timeout_next_s   = 1'b1;
          cnt_next_s       = CNT_ZERO;
          state_next_s     = IDLE;
        end else begin
          cnt_next_s       = cnt_inc_s;
        end
      end

      LOW: begin
        if (rise_s) begin
          period_next_s     = cnt_r;
          cnt_next_s        = CNT_ONE;
          edge_count_next_s = edge_count + CNT_ONE;
          meas_valid_next_s = 1'b1;
          state_next_s      = HIGH;
`ifdef PERIOD_CHECK_EN
          if (cnt_r != exp_period) begin
            period_err_next_s = 1'b1;
          end else begin
            period_err_next_s = period_err;
          end
`endif
        end else if (sat_s) begin
          timeout_next_s    = 1'b1;
          cnt_next_s        = CNT_ZERO;
          state_next_s      = IDLE;
        end else begin
          cnt_next_s        = cnt_inc_s;
        end
      end

      default: begin
        cnt_next_s   = CNT_ZERO;
        state_next_s = IDLE;
      end
    endcase

`ifndef PERIOD_CHECK_EN
    period_err_next_s = 1'b0;
`endif
  end

`ifndef PERIOD_CHECK_EN
  // The expected period only matters when the checker is built in.
  logic unused_exp_s;
  assign unused_exp_s = ^exp_period;
`endif

endmodule
